// File: rtl/sipo_deframer_pkg.sv
// Shared constants for the serializer/deserializer pair: default width and bit-order encoding.
package sipo_deframer_pkg;

    localparam int unsigned DEFAULT_N   = 16;
    localparam bit          MSB_FIRST_C = 1'b1;
    localparam bit          LSB_FIRST_C = 1'b0;

endpackage : sipo_deframer_pkg

// File: rtl/sipo_deframer_core.sv
// Shift register and bit counter with sync realignment; flags the edge that completes a word.
module sipo_deframer_core
    import sipo_deframer_pkg::*;
#(
    parameter int unsigned N         = DEFAULT_N,
    parameter bit          MSB_FIRST = MSB_FIRST_C,
    localparam int unsigned CW       = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          din,
    input  logic          din_valid,
    input  logic          sync,
    output logic [N-1:0]  word_c,
    output logic          done_c,
    output logic [CW-1:0] bit_cnt
);

    logic [N-1:0] sh;
    logic [N-1:0] sh_next;
    logic [N-1:0] sh_sync;

    // Next shift value including the incoming bit, and the value a sync restarts from.
    always_comb begin
        sh_next = sh;
        sh_sync = '0;
        if (MSB_FIRST) begin
            sh_next = {sh[N-2:0], din};
            sh_sync = {{(N-1){1'b0}}, din};
        end else begin
            sh_next = {din, sh[N-1:1]};
            sh_sync = {din, {(N-1){1'b0}}};
        end
    end

    // A word completes on the Nth qualified bit unless sync discards it.
    always_comb begin
        word_c = sh_next;
        done_c = din_valid && !sync && (bit_cnt == CW'(N - 1));
    end

    // Shift/count state; sync restarts the word, keeping a coincident bit as bit 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh      <= '0;
            bit_cnt <= '0;
        end else if (sync) begin
            sh      <= din_valid ? sh_sync : '0;
            bit_cnt <= din_valid ? CW'(1) : '0;
        end else if (din_valid) begin
            sh      <= sh_next;
            bit_cnt <= done_c ? '0 : bit_cnt + CW'(1);
        end
    end

endmodule : sipo_deframer_core

// File: rtl/sipo_deframer.sv
// Serial-to-parallel deframer: core assembler plus one-entry valid/ready buffer and sticky overrun.
module sipo_deframer
    import sipo_deframer_pkg::*;
#(
    parameter int unsigned N         = DEFAULT_N,
    parameter bit          MSB_FIRST = MSB_FIRST_C,
    localparam int unsigned CW       = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          din,
    input  logic          din_valid,
    input  logic          sync,
    output logic [N-1:0]  word_out,
    output logic          word_valid,
    input  logic          word_ready,
    output logic          overrun,
    input  logic          clr_overrun,
    output logic [CW-1:0] bit_cnt
);

    logic [N-1:0] word_c;
    logic         done_c;
    logic         pop_c;
    logic         load_c;
    logic         drop_c;

    sipo_deframer_core #(
        .N         (N),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .sync      (sync),
        .word_c    (word_c),
        .done_c    (done_c),
        .bit_cnt   (bit_cnt)
    );

    // Buffer decisions: a completion loads if the slot is free or being drained, else drops.
    always_comb begin
        pop_c  = word_valid && word_ready;
        load_c = done_c && (!word_valid || word_ready);
        drop_c = done_c && word_valid && !word_ready;
    end

    // Output slot; word_out only moves on a load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_out   <= '0;
            word_valid <= 1'b0;
        end else if (load_c) begin
            word_out   <= word_c;
            word_valid <= 1'b1;
        end else if (pop_c) begin
            word_valid <= 1'b0;
        end
    end

    // Sticky overrun; a drop on the same edge as a clear keeps it set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun <= 1'b0;
        end else if (drop_c) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

endmodule : sipo_deframer
